msp430_regfile: RTL and testbench
=================================

// Module: msp430_regfile
// PURPOSE
//  Datapath responder to the control unit's control lines: 16x16 register file, MAR, S (source
//  temp) register, MSP430 addressing-mode / constant-generator logic and sync-RAM port.
//  Executes each cycle's regno/As/reg_inc/reg_store/ram_read/ram_store/s_store/s_read
//  command and returns instruction/operand words on data_out.
// PARAMETERS
//  RESET_PC  16'h0000  value loaded into R0 (PC) on reset
// PORTS
//  clk        in   1   clock, all state on posedge
//  arst       in   1   reset, asynchronous, active-high
//  bytemode   in   1   byte operation (B/W bit)
//  As         in   2   addressing mode (As, or {0,Ad} on destination)
//  regno      in   4   register selected this cycle
//  reg_store  in   1   write S (s_read=1) into R[regno]
//  reg_inc    in   1   load MAR from R[regno], then post-increment R[regno]
//  ram_store  in   1   write S to memory at MAR
//  ram_read   in   1   memory read data (from last MAR load) valid this cycle
//  s_store    in   1   load S register
//  s_read     in   1   S drives write-back bus
//  data_out   out  16  mem_rdata when ram_read, else 0; feeds control unit's data_in
//  mem_addr   out  16  RAM address (next-MAR value when mem_re, else MAR)
//  mem_re     out  1   RAM read strobe; rdata valid exactly 1 cycle later
//  mem_we     out  1   RAM write strobe (= ram_store)
//  mem_wdata  out  16  = S (bytemode: {S[7:0],S[7:0]})
//  mem_rdata  in   16  RAM read data
// BEHAVIOUR
//  Reset: R0<=RESET_PC, R1..R15<=0, MAR<=0, S<=0; outputs mem_re=0, mem_we=0, data_out=0,
//   mem_addr=0, mem_wdata=0. Reset mid-sequence aborts it; no write completes after arst rises.
//  Operand value OP (comb.) from regno/As:
//   R3: As 0->0, 1->1, 2->2, 3->16'hFFFF.  R2: As2->4, As3->8, As1->base 0 (absolute).
//   Other regs: OP=R[regno]. bytemode masks OP to {8'h00,OP[7:0]} for S loads only.
//  MAR load (mem_re=1, mem_addr=new MAR, rdata valid next cycle):
//   - reg_inc: MAR<=R[regno]; R[regno]+=inc, inc=1 if bytemode & regno>1, else 2 (PC/SP even).
//   - As in {2,3} & ~CG (regno!=3, !(regno==2)): MAR<=R[regno]; As3 without reg_inc: no inc.
//   - ram_read & As==1: indexed, MAR<=base+mem_rdata (16-bit wrap), base=R[regno], 0 for R2.
//   - otherwise MAR holds, mem_re=0.
//  S register: s_store & ram_read & As!=1 -> S<=mem_rdata (byte-masked);
//   s_store & ~ram_read -> S<=OP; later s_store cycles overwrite earlier ones.
//  Write-back: reg_store & s_read & As[0]==0 -> R[regno]<=S (bytemode: {8'h00,S[7:0]}).
//   reg_store with As[0]==1 ignored (indexed dest handled via ram_store). Writes to R3 ignored.
//   Writes to R0/R1 force bit0=0.
//  Simultaneous: reg_store and reg_inc on same reg -> store wins; reg_store reads pre-edge S
//   even if s_store same cycle; ram_store & mem_re same cycle -> write uses old MAR, mem_addr
//   shows old MAR, mem_re suppressed (write priority) and read repeats next cycle.
//  Increments wrap 16'hFFFE+2 -> 16'h0000 (PC), 16'hFFFF+1 -> 16'h0000.
// CONFIGURATION
//  MSP430_RF_DBG_EN defined: adds ports dbg_regno in 4, dbg_data out 16 = R[dbg_regno]
//   (comb., R3 reads 0), for bench/JTAG inspection; no effect on datapath timing.
//  Undefined: ports absent; register contents observable only via data path.
// TESTING
//  1 arst pulse during index sequence -> R0=RESET_PC, S=0, mem_re=0, mem_we=0 immediately.
//  2 R0=16'h0100, regno=0 As=0 reg_inc -> mem_addr=16'h0100 mem_re=1, R0=16'h0102; next cycle
//    ram_read, mem_rdata=16'h4F0A -> data_out=16'h4F0A.
//  3 s_store regno=3 As=3 -> S=16'hFFFF; regno=2 As=2 -> S=16'h0004; then S=16'hFFFF,
//    reg_store s_read bytemode regno=5 -> R5=16'h00FF; reg_store regno=3 -> R3 unchanged.
//  4 R6=16'h0200 As=3 reg_inc: bytemode=1 -> mem_addr 16'h0200, R6=16'h0201; bytemode=0 ->
//    R6=16'h0203; regno=0 bytemode=1 -> PC+=2.
//  5 R7=16'h0300, ram_read As=1 regno=7 mem_rdata=16'h0010 -> mem_addr=16'h0310; regno=2 ->
//    16'h0010; R7=16'hFFF8 + 16'h0010 -> 16'h0008.
//  6 reg_store+reg_inc regno=4, S=16'h1234 -> R4=16'h1234; ram_store bytemode S=16'h00AB ->
//    mem_we=1 mem_addr=MAR mem_wdata=16'hABAB.

Source files
------------

// File: rtl/msp430_regfile_if.sv
// Control-unit and RAM-side signals of the MSP430 register-file datapath.
// master: control unit / RAM model side; slave: msp430_regfile.
interface msp430_regfile_if;
    logic        bytemode;
    logic [1:0]  As;
    logic [3:0]  regno;
    logic        reg_store;
    logic        reg_inc;
    logic        ram_store;
    logic        ram_read;
    logic        s_store;
    logic        s_read;
    logic [15:0] data_out;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport master (
        output bytemode, As, regno, reg_store, reg_inc, ram_store, ram_read,
               s_store, s_read, mem_rdata,
        input  data_out, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        input  bytemode, As, regno, reg_store, reg_inc, ram_store, ram_read,
               s_store, s_read, mem_rdata,
        output data_out, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/msp430_regfile.sv
// MSP430 datapath: 16x16 register file, MAR, S register, constant generator and RAM port.
// Optional MSP430_RF_DBG_EN adds a combinational register peek port (dbg_regno/dbg_data).
module msp430_regfile #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            arst,
`ifdef MSP430_RF_DBG_EN
    input  logic [3:0]      dbg_regno,
    output logic [15:0]     dbg_data,
`endif
    msp430_regfile_if.slave bus
);
    logic [15:0] r_regs [16];
    logic [15:0] r_mar;
    logic [15:0] r_s;
    logic        r_rd_pend;

    logic [15:0] w_rval;
    logic [15:0] w_op;
    logic [15:0] w_s_op;
    logic [15:0] w_s_mem;
    logic [15:0] w_mar_next;
    logic [15:0] w_idx_base;
    logic [15:0] w_wb_val;
    logic [15:0] w_inc_step;
    logic [15:0] w_inc_val;
    logic        w_is_cg;
    logic        w_ld_ptr;
    logic        w_ld_idx;
    logic        w_ld_mar;
    logic        w_rd_req;
    logic        w_wb_en;
    logic        w_inc_en;

    assign w_rval = r_regs[bus.regno];

    // R3 is a pure constant source; R2 supplies constants for As 2/3 and base 0 for absolute.
    always_comb begin
        w_op = w_rval;
        if (bus.regno == 4'd3) begin
            case (bus.As)
                2'd0:    w_op = 16'h0000;
                2'd1:    w_op = 16'h0001;
                2'd2:    w_op = 16'h0002;
                default: w_op = 16'hFFFF;
            endcase
        end else if (bus.regno == 4'd2) begin
            case (bus.As)
                2'd1:    w_op = 16'h0000;
                2'd2:    w_op = 16'h0004;
                2'd3:    w_op = 16'h0008;
                default: w_op = w_rval;
            endcase
        end
    end

    assign w_s_op  = bus.bytemode ? {8'h00, w_op[7:0]} : w_op;
    assign w_s_mem = bus.bytemode ? {8'h00, bus.mem_rdata[7:0]} : bus.mem_rdata;

    assign w_is_cg    = (bus.regno == 4'd3) || (bus.regno == 4'd2);
    assign w_ld_ptr   = bus.reg_inc || (bus.As[1] && !w_is_cg);
    assign w_ld_idx   = bus.ram_read && (bus.As == 2'd1) && (bus.regno != 4'd3);
    assign w_ld_mar   = w_ld_ptr || w_ld_idx;
    assign w_idx_base = (bus.regno == 4'd2) ? 16'h0000 : w_rval;

    always_comb begin
        w_mar_next = r_mar;
        if (w_ld_ptr)
            w_mar_next = w_rval;
        else if (w_ld_idx)
            w_mar_next = w_idx_base + bus.mem_rdata;
    end

    // A read blocked by a same-cycle RAM write is re-issued from the updated MAR next cycle.
    assign w_rd_req = w_ld_mar || r_rd_pend;

    assign w_wb_en = bus.reg_store && bus.s_read && !bus.As[0] && (bus.regno != 4'd3);
    always_comb begin
        w_wb_val = bus.bytemode ? {8'h00, r_s[7:0]} : r_s;
        if (bus.regno <= 4'd1)
            w_wb_val[0] = 1'b0;
    end

    assign w_inc_en   = bus.reg_inc && (bus.regno != 4'd3) && !w_wb_en;
    assign w_inc_step = (bus.bytemode && (bus.regno > 4'd1)) ? 16'h0001 : 16'h0002;
    assign w_inc_val  = w_rval + w_inc_step;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < 16; i++)
                r_regs[i] <= (i == 0) ? RESET_PC : 16'h0000;
            r_mar     <= 16'h0000;
            r_s       <= 16'h0000;
            r_rd_pend <= 1'b0;
        end else begin
            if (w_wb_en)
                r_regs[bus.regno] <= w_wb_val;
            else if (w_inc_en)
                r_regs[bus.regno] <= w_inc_val;
            if (w_ld_mar)
                r_mar <= w_mar_next;
            r_rd_pend <= w_rd_req && bus.ram_store;
            if (bus.s_store) begin
                if (!bus.ram_read)
                    r_s <= w_s_op;
                else if (bus.As != 2'd1)
                    r_s <= w_s_mem;
            end
        end
    end

    // Outputs are forced quiet while arst is high so nothing reaches the RAM during reset.
    assign bus.mem_re    = !arst && w_rd_req && !bus.ram_store;
    assign bus.mem_we    = !arst && bus.ram_store;
    assign bus.mem_addr  = arst ? 16'h0000 :
                           (w_ld_mar && !bus.ram_store) ? w_mar_next : r_mar;
    assign bus.mem_wdata = arst ? 16'h0000 :
                           bus.bytemode ? {r_s[7:0], r_s[7:0]} : r_s;
    assign bus.data_out  = (!arst && bus.ram_read) ? bus.mem_rdata : 16'h0000;

`ifdef MSP430_RF_DBG_EN
    assign dbg_data = (dbg_regno == 4'd3) ? 16'h0000 : r_regs[dbg_regno];
`endif
endmodule

// File: tb/tb_msp430_regfile.sv
// Directed bench for msp430_regfile: register contents are observed through the
// data path (indirect MAR loads for registers, a RAM write for the S register).
module tb_msp430_regfile;
    localparam logic [15:0] RST_PC = 16'h0100;

    logic clk = 1'b0;
    logic arst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [15:0] v;

    msp430_regfile_if bus();
`ifdef MSP430_RF_DBG_EN
    logic [3:0]  dbg_regno;
    logic [15:0] dbg_data;
    assign dbg_regno = 4'd0;
`endif

    msp430_regfile #(.RESET_PC(RST_PC)) dut (
        .clk       (clk),
        .arst      (arst),
`ifdef MSP430_RF_DBG_EN
        .dbg_regno (dbg_regno),
        .dbg_data  (dbg_data),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.bytemode  = 1'b0;
        bus.As        = 2'd0;
        bus.regno     = 4'd0;
        bus.reg_store = 1'b0;
        bus.reg_inc   = 1'b0;
        bus.ram_store = 1'b0;
        bus.ram_read  = 1'b0;
        bus.s_store   = 1'b0;
        bus.s_read    = 1'b0;
        bus.mem_rdata = 16'h0000;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load_s(input logic [15:0] val, input logic bm);
        idle();
        bus.s_store   = 1'b1;
        bus.ram_read  = 1'b1;
        bus.bytemode  = bm;
        bus.mem_rdata = val;
        next();
    endtask

    task automatic set_reg(input logic [3:0] n, input logic [15:0] val);
        load_s(val, 1'b0);
        bus.regno     = n;
        bus.reg_store = 1'b1;
        bus.s_read    = 1'b1;
        next();
    endtask

    task automatic check_reg(input string tag, input logic [3:0] n, input logic [15:0] exp);
        idle();
        bus.regno = n;
        bus.As    = 2'd2;
        @(negedge clk);
        chk(tag, bus.mem_addr, exp);
        next();
    endtask

    task automatic check_s(input string tag, input logic [15:0] exp);
        idle();
        bus.ram_store = 1'b1;
        @(negedge clk);
        chk(tag, bus.mem_wdata, exp);
        next();
    endtask

    initial begin
        idle();
        arst          = 1'b1;
        bus.ram_store = 1'b1;
        bus.ram_read  = 1'b1;
        bus.reg_inc   = 1'b1;
        bus.regno     = 4'd4;
        bus.mem_rdata = 16'hFFFF;
        #12;
        chk("rst_mem_re",    bus.mem_re,    16'h0000);
        chk("rst_mem_we",    bus.mem_we,    16'h0000);
        chk("rst_data_out",  bus.data_out,  16'h0000);
        chk("rst_mem_addr",  bus.mem_addr,  16'h0000);
        chk("rst_mem_wdata", bus.mem_wdata, 16'h0000);
        idle();
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;
        check_reg("rst_r0", 4'd0, RST_PC);
        check_reg("rst_r7", 4'd7, 16'h0000);

        // Instruction fetch through PC
        bus.reg_inc = 1'b1;
        @(negedge clk);
        chk("fetch_addr", bus.mem_addr, 16'h0100);
        chk("fetch_re",   bus.mem_re,   16'h0001);
        next();
        bus.ram_read  = 1'b1;
        bus.mem_rdata = 16'h4F0A;
        @(negedge clk);
        chk("fetch_data", bus.data_out, 16'h4F0A);
        next();
        check_reg("fetch_pc", 4'd0, 16'h0102);

        // Constant generator and byte write-back
        bus.s_store = 1'b1; bus.regno = 4'd3; bus.As = 2'd3;
        next();
        check_s("cg_r3_as3", 16'hFFFF);
        bus.s_store = 1'b1; bus.regno = 4'd2; bus.As = 2'd2;
        next();
        check_s("cg_r2_as2", 16'h0004);
        bus.s_store = 1'b1; bus.regno = 4'd3; bus.As = 2'd3;
        next();
        bus.reg_store = 1'b1; bus.s_read = 1'b1; bus.bytemode = 1'b1; bus.regno = 4'd5;
        next();
        check_reg("wb_byte_r5", 4'd5, 16'h00FF);
        bus.reg_store = 1'b1; bus.s_read = 1'b1; bus.regno = 4'd3;
        next();
        bus.reg_inc = 1'b1; bus.regno = 4'd3;
        @(negedge clk);
        chk("r3_unwritable", bus.mem_addr, 16'h0000);
        next();

        // Autoincrement step sizes
        set_reg(4'd6, 16'h0200);
        bus.reg_inc = 1'b1; bus.regno = 4'd6; bus.As = 2'd3; bus.bytemode = 1'b1;
        @(negedge clk);
        chk("ainc_addr", bus.mem_addr, 16'h0200);
        next();
        check_reg("ainc_byte", 4'd6, 16'h0201);
        bus.reg_inc = 1'b1; bus.regno = 4'd6; bus.As = 2'd3;
        next();
        check_reg("ainc_word", 4'd6, 16'h0203);
        bus.reg_inc = 1'b1; bus.bytemode = 1'b1;
        @(negedge clk);
        chk("pc_byte_addr", bus.mem_addr, 16'h0102);
        next();
        check_reg("pc_byte_inc", 4'd0, 16'h0104);

        // Indexed and absolute address calculation
        set_reg(4'd7, 16'h0300);
        bus.ram_read = 1'b1; bus.As = 2'd1; bus.regno = 4'd7; bus.mem_rdata = 16'h0010;
        @(negedge clk);
        chk("idx_addr", bus.mem_addr, 16'h0310);
        chk("idx_re",   bus.mem_re,   16'h0001);
        next();
        bus.ram_read = 1'b1; bus.As = 2'd1; bus.regno = 4'd2; bus.mem_rdata = 16'h0010;
        @(negedge clk);
        chk("abs_addr", bus.mem_addr, 16'h0010);
        next();
        set_reg(4'd7, 16'hFFF8);
        bus.ram_read = 1'b1; bus.As = 2'd1; bus.regno = 4'd7; bus.mem_rdata = 16'h0010;
        @(negedge clk);
        chk("idx_wrap", bus.mem_addr, 16'h0008);
        next();

        // Store beats increment; byte RAM write replicates low byte
        set_reg(4'd4, 16'h0050);
        load_s(16'h1234, 1'b0);
        bus.reg_store = 1'b1; bus.reg_inc = 1'b1; bus.s_read = 1'b1; bus.regno = 4'd4;
        @(negedge clk);
        chk("st_inc_addr", bus.mem_addr, 16'h0050);
        next();
        check_reg("st_wins", 4'd4, 16'h1234);
        load_s(16'h12AB, 1'b1);
        check_s("s_byte_mask", 16'h00AB);
        bus.ram_store = 1'b1; bus.bytemode = 1'b1;
        @(negedge clk);
        chk("wr_we",    bus.mem_we,    16'h0001);
        chk("wr_addr",  bus.mem_addr,  16'h1234);
        chk("wr_wdata", bus.mem_wdata, 16'hABAB);
        chk("wr_re",    bus.mem_re,    16'h0000);
        next();

        // PC/SP bit0, indexed-destination write-back ignore, increment wrap
        set_reg(4'd0, 16'h0301);
        check_reg("pc_bit0", 4'd0, 16'h0300);
        load_s(16'h5555, 1'b0);
        bus.reg_store = 1'b1; bus.s_read = 1'b1; bus.As = 2'd1; bus.regno = 4'd8;
        next();
        check_reg("wb_as1_ignored", 4'd8, 16'h0000);
        set_reg(4'd9, 16'hFFFF);
        bus.reg_inc = 1'b1; bus.regno = 4'd9; bus.bytemode = 1'b1;
        next();
        check_reg("wrap_byte", 4'd9, 16'h0000);
        set_reg(4'd0, 16'hFFFE);
        bus.reg_inc = 1'b1;
        next();
        check_reg("wrap_pc", 4'd0, 16'h0000);

        // RAM write collides with a MAR load: write first, read re-issued next cycle
        set_reg(4'd10, 16'h0400);
        check_reg("pre_r5", 4'd5, 16'h00FF);
        bus.reg_inc = 1'b1; bus.regno = 4'd10; bus.ram_store = 1'b1;
        @(negedge clk);
        chk("coll_addr", bus.mem_addr, 16'h00FF);
        chk("coll_re",   bus.mem_re,   16'h0000);
        chk("coll_we",   bus.mem_we,   16'h0001);
        next();
        @(negedge clk);
        chk("retry_re",   bus.mem_re,   16'h0001);
        chk("retry_addr", bus.mem_addr, 16'h0400);
        next();
        check_reg("coll_r10", 4'd10, 16'h0402);

        // Reset in the middle of an indexed access
        load_s(16'hBEEF, 1'b0);
        bus.ram_read = 1'b1; bus.As = 2'd1; bus.regno = 4'd7;
        bus.mem_rdata = 16'h0010; bus.ram_store = 1'b1;
        #1;
        arst = 1'b1;
        #1;
        chk("mid_rst_re", bus.mem_re,   16'h0000);
        chk("mid_rst_we", bus.mem_we,   16'h0000);
        chk("mid_rst_do", bus.data_out, 16'h0000);
        idle();
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;
        check_reg("mid_rst_r0", 4'd0, RST_PC);
        check_s("mid_rst_s", 16'h0000);
        check_reg("mid_rst_r7", 4'd7, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
